// File: rtl/arts_pkg.sv
// ---------------------------------------------------------------------------
// arts_pkg
// Shared definitions for the ARTS approximate multiplier datapath.
//   - state_t   : dot-accumulator FSM encoding (IDLE/ACC/HOLD)
//   - ARTS_PW   : width of the 16x16 ARTS multiplier product
// ---------------------------------------------------------------------------
package arts_pkg;

    localparam int ARTS_PW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/arts_dot_accumulator_if.sv
// ---------------------------------------------------------------------------
// arts_dot_accumulator_if
// Product input handshake and result output handshake for the dot-product
// accumulator.
//   master : producer/consumer side (drives in_valid/in_prod/in_last and
//            out_ready)
//   slave  : accumulator side (drives in_ready and the out_* result)
// ---------------------------------------------------------------------------
interface arts_dot_accumulator_if
    import arts_pkg::*;
#(
    parameter int PW = ARTS_PW,
    parameter int AW = 40,
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_sat;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );

endinterface

// File: rtl/arts_sat_add.sv
// ---------------------------------------------------------------------------
// arts_sat_add
// Combinational unsigned saturating adder.
//   a     : AW-bit running value
//   b     : BW-bit addend (BW <= AW), zero-extended
//   sum   : a + b, clamped to 2^AW-1
//   clamp : 1 when the true sum did not fit in AW bits
// ---------------------------------------------------------------------------
module arts_sat_add #(
    parameter int AW = 40,
    parameter int BW = 32
) (
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          clamp
);

    // One extra bit holds the carry-out, which is exactly the overflow flag.
    logic [AW:0] full_sum;

    assign full_sum = {1'b0, a} + (AW+1)'(b);
    assign clamp    = full_sum[AW];
    assign sum      = full_sum[AW] ? {AW{1'b1}} : full_sum[AW-1:0];

endmodule

// File: rtl/arts_dot_accumulator.sv
// ---------------------------------------------------------------------------
// arts_dot_accumulator
// Sums a vector of unsigned ARTS products (one per cycle, vector terminated
// by in_last) and presents the saturated sum, saturated element count and a
// sticky saturation flag on an output handshake.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of arts_dot_accumulator_if
//            in_valid/in_ready/in_prod/in_last    product stream
//            out_valid/out_ready/out_sum/out_count/out_sat  result
// ---------------------------------------------------------------------------
module arts_dot_accumulator
    import arts_pkg::*;
#(
    parameter int PW = ARTS_PW,
    parameter int AW = 40,
    parameter int CW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    arts_dot_accumulator_if.slave   bus
);

    state_t        state_reg, state_next;
    logic [AW-1:0] acc_reg,   acc_next;
    logic [CW-1:0] count_reg, count_next;
    logic          sat_reg,   sat_next;

    logic          accept;
    logic [AW-1:0] acc_add;
    logic          acc_clamp;
    logic [CW-1:0] count_add;
    logic          count_clamp;

    arts_sat_add #(.AW(AW), .BW(PW)) u_acc_add (
        .a     (acc_reg),
        .b     (bus.in_prod),
        .sum   (acc_add),
        .clamp (acc_clamp)
    );

    arts_sat_add #(.AW(CW), .BW(1)) u_count_add (
        .a     (count_reg),
        .b     (1'b1),
        .sum   (count_add),
        .clamp (count_clamp)
    );

    // Handshake outputs decode only the state register, so there is no
    // combinational path from in_valid or out_ready.
    assign bus.in_ready  = (state_reg != HOLD);
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.out_sum   = acc_reg;
    assign bus.out_count = count_reg;
    assign bus.out_sat   = sat_reg;

    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            sat_reg   <= sat_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        sat_next   = sat_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    // First element restarts the vector and drops the
                    // previous sticky flag.
                    acc_next   = AW'(bus.in_prod);
                    count_next = CW'(1);
                    sat_next   = 1'b0;
                    state_next = bus.in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_next   = acc_add;
                    count_next = count_add;
                    sat_next   = sat_reg | acc_clamp | count_clamp;
                    state_next = bus.in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
